// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Data wins ties unless fetch has waited out MAX_DATA_STREAK data grants; BUSY aborts after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t              r_state;
    state_t              w_nextState;
    owner_t              r_owner;
    logic [STREAK_W-1:0] r_streak;
    logic [7:0]          r_timer;
    logic                w_anyReq;
    logic                w_grantD;
    logic                w_timeoutHit;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Fetch only overrides a pending data request once the streak has saturated.
    always_comb begin
        w_anyReq     = i_req | d_req;
        w_grantD     = d_req && !(i_req && (r_streak == STREAK_W'(MAX_DATA_STREAK)));
        w_timeoutHit = !mem_ready && (r_timer == 8'(TIMEOUT - 1));
        w_nextState  = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = BUSY;
            BUSY:    if (mem_ready || w_timeoutHit) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign i_ack = (r_state == DONE) && (r_owner == OWN_I);
    assign d_ack = (r_state == DONE) && (r_owner == OWN_D);
    assign busy  = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= OWN_NONE;
            r_streak    <= '0;
            r_timer     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= 4'b0000;
            i_rdata     <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (!i_req) r_streak <= '0;
                    if (w_anyReq) begin
                        mem_req <= 1'b1;
                        if (w_grantD) begin
                            r_owner   <= OWN_D;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                            if (i_req && (r_streak != STREAK_W'(MAX_DATA_STREAK)))
                                r_streak <= r_streak + 1'b1;
                        end else begin
                            r_owner   <= OWN_I;
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_be    <= 4'b1111;
                            r_streak  <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (r_owner == OWN_D) d_rdata <= mem_rdata;
                        else                  i_rdata <= mem_rdata;
                    end else if (w_timeoutHit) begin
                        // Abort returns a NOP so a starved fetch cannot inject garbage into the pipeline.
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        if (r_owner == OWN_D) d_rdata <= NOP_INSN;
                        else                  i_rdata <= NOP_INSN;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                DONE: r_owner <= OWN_NONE;
                default: r_owner <= OWN_NONE;
            endcase
        end
    end

endmodule
